psm_result_collector: RTL and testbench

- Sits directly downstream of the 3-phase logic sequencer (Ready/Op1/Op2/Op3 strobes plus 8-bit Dout).
- Tracks the sequencer's phase strobes and captures the final Dout of each phase.
- Checks each phase's length and ordering, then forms a 10-bit checksum.
- Presents one packed result per completed run to the next stage through a single-entry Valid/Accept output register, flagging overruns and protocol errors.

---
 rtl/psm_result_collector.sv | 173 +++++++++++++++++
 tb/tb_psm_result_collector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psm_result_collector.sv
// Collects the Op1/Op2/Op3 data captured from the 3-phase sequencer and checks phase lengths.
// Each completed run is published through a single-entry Valid/Accept result register.
module psm_result_collector #(
  parameter int unsigned LEN1 = 2,
  parameter int unsigned LEN2 = 5,
  parameter int unsigned LEN3 = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PsmReady,
  input  logic       PsmOp1,
  input  logic       PsmOp2,
  input  logic       PsmOp3,
  input  logic [7:0] PsmDout,
  output logic [7:0] ResOr,
  output logic [7:0] ResXor,
  output logic [7:0] ResOrn,
  output logic [9:0] Sum,
  output logic       LenErr,
  output logic       Valid,
  input  logic       Accept,
  output logic       SeqErr,
  output logic       Overrun,
  output logic       Busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CAP1 = 2'd1;
  localparam logic [1:0] CAP2 = 2'd2;
  localparam logic [1:0] CAP3 = 2'd3;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic [2:0] mm_q, mm_d;
  logic [7:0] res_or_d, res_xor_d, res_orn_d;
  logic [9:0] sum_d;
  logic       len_err_d, valid_d, seq_err_d, overrun_d;
  logic       multi, complete;

  assign multi   = !$onehot0({PsmReady, PsmOp1, PsmOp2, PsmOp3});
  assign cnt_inc = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    c1_d      = c1_q;
    c2_d      = c2_q;
    c3_d      = c3_q;
    mm_d      = mm_q;
    seq_err_d = SeqErr;
    complete  = 1'b0;
    if (multi) begin
      seq_err_d = 1'b1;
      state_d   = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (PsmOp1) begin
            c1_d    = PsmDout;
            cnt_d   = 3'd1;
            mm_d    = '0;
            state_d = CAP1;
          end
        end
        CAP1: begin
          if (PsmOp1) begin
            c1_d  = PsmDout;
            cnt_d = cnt_inc;
          end else if (PsmOp2) begin
            mm_d[0] = ({29'd0, cnt_q} != LEN1);
            c2_d    = PsmDout;
            cnt_d   = 3'd1;
            state_d = CAP2;
          end else begin
            seq_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
        CAP2: begin
          if (PsmOp2) begin
            c2_d  = PsmDout;
            cnt_d = cnt_inc;
          end else if (PsmOp3) begin
            mm_d[1] = ({29'd0, cnt_q} != LEN2);
            c3_d    = PsmDout;
            cnt_d   = 3'd1;
            state_d = CAP3;
          end else begin
            seq_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
        CAP3: begin
          if (PsmOp3) begin
            c3_d  = PsmDout;
            cnt_d = cnt_inc;
          end else if (PsmReady) begin
            mm_d[2]  = ({29'd0, cnt_q} != LEN3);
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            seq_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A completion may overwrite a held result only if it is being accepted at the same edge.
  always_comb begin
    res_or_d  = ResOr;
    res_xor_d = ResXor;
    res_orn_d = ResOrn;
    sum_d     = Sum;
    len_err_d = LenErr;
    valid_d   = Valid;
    overrun_d = Overrun;
    if (complete) begin
      if (!Valid || Accept) begin
        res_or_d  = c1_q;
        res_xor_d = c2_q;
        res_orn_d = c3_q;
        sum_d     = {2'b00, c1_q} + {2'b00, c2_q} + {2'b00, c3_q};
        len_err_d = |mm_d;
        valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (Valid && Accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      c3_q    <= '0;
      mm_q    <= '0;
      ResOr   <= '0;
      ResXor  <= '0;
      ResOrn  <= '0;
      Sum     <= '0;
      LenErr  <= 1'b0;
      Valid   <= 1'b0;
      SeqErr  <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      c3_q    <= c3_d;
      mm_q    <= mm_d;
      ResOr   <= res_or_d;
      ResXor  <= res_xor_d;
      ResOrn  <= res_orn_d;
      Sum     <= sum_d;
      LenErr  <= len_err_d;
      Valid   <= valid_d;
      SeqErr  <= seq_err_d;
      Overrun <= overrun_d;
    end
  end

  assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_psm_result_collector.sv
// Directed bench for psm_result_collector: expected results are queued as runs are driven
// and compared when the collector presents them.
module tb_psm_result_collector;

  logic       Clock, Reset;
  logic       PsmReady, PsmOp1, PsmOp2, PsmOp3;
  logic [7:0] PsmDout;
  logic [7:0] ResOr, ResXor, ResOrn;
  logic [9:0] Sum;
  logic       LenErr, Valid, Accept, SeqErr, Overrun, Busy;

  psm_result_collector #(.LEN1(2), .LEN2(5), .LEN3(3)) dut (
    .Clock(Clock), .Reset(Reset),
    .PsmReady(PsmReady), .PsmOp1(PsmOp1), .PsmOp2(PsmOp2), .PsmOp3(PsmOp3),
    .PsmDout(PsmDout),
    .ResOr(ResOr), .ResXor(ResXor), .ResOrn(ResOrn), .Sum(Sum),
    .LenErr(LenErr), .Valid(Valid), .Accept(Accept),
    .SeqErr(SeqErr), .Overrun(Overrun), .Busy(Busy)
  );

  typedef struct packed {
    logic [7:0] r_or;
    logic [7:0] r_xor;
    logic [7:0] r_orn;
    logic [9:0] sum;
    logic       len_err;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic o1, input logic o2, input logic o3,
                       input logic [7:0] d);
    PsmReady = r;
    PsmOp1   = o1;
    PsmOp2   = o2;
    PsmOp3   = o3;
    PsmDout  = d;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    PsmReady = 0; PsmOp1 = 0; PsmOp2 = 0; PsmOp3 = 0; PsmDout = 8'h00;
  endtask

  function automatic int sat7(input int n);
    return (n > 7) ? 7 : n;
  endfunction

  task automatic push_exp(input int n1, input logic [7:0] d1, input int n2,
                          input logic [7:0] d2, input int n3, input logic [7:0] d3);
    res_t e;
    e.r_or    = d1;
    e.r_xor   = d2;
    e.r_orn   = d3;
    e.sum     = 10'(d1) + 10'(d2) + 10'(d3);
    e.len_err = (sat7(n1) != 2) || (sat7(n2) != 5) || (sat7(n3) != 3);
    exp_q.push_back(e);
  endtask

  // Full run: Op1 x n1, Op2 x n2, Op3 x n3, then one Ready cycle.
  task automatic run(input int n1, input logic [7:0] d1, input int n2, input logic [7:0] d2,
                     input int n3, input logic [7:0] d3, input logic acc_on_ready);
    for (int i = 0; i < n1; i++) drive(0, 1, 0, 0, d1);
    for (int i = 0; i < n2; i++) drive(0, 0, 1, 0, d2);
    for (int i = 0; i < n3; i++) drive(0, 0, 0, 1, d3);
    Accept = acc_on_ready;
    drive(1, 0, 0, 0, 8'h00);
    Accept = 0;
    idle_inputs();
  endtask

  task automatic check_result(input string tag);
    res_t e;
    int   w = 0;
    while (!Valid && w < 5) begin
      @(posedge Clock);
      #1;
      w++;
    end
    chk({tag, "_valid"}, Valid, 1);
    chk({tag, "_queued"}, (exp_q.size() != 0), 1);
    if (Valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_or"}, ResOr, e.r_or);
      chk({tag, "_xor"}, ResXor, e.r_xor);
      chk({tag, "_orn"}, ResOrn, e.r_orn);
      chk({tag, "_sum"}, Sum, e.sum);
      chk({tag, "_lenerr"}, LenErr, e.len_err);
    end
  endtask

  task automatic accept_pulse(input string tag);
    Accept = 1;
    @(posedge Clock);
    #1;
    Accept = 0;
    chk({tag, "_valid_cleared"}, Valid, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_or"}, ResOr, 0);
    chk({tag, "_xor"}, ResXor, 0);
    chk({tag, "_orn"}, ResOrn, 0);
    chk({tag, "_sum"}, Sum, 0);
    chk({tag, "_lenerr"}, LenErr, 0);
    chk({tag, "_valid"}, Valid, 0);
    chk({tag, "_seqerr"}, SeqErr, 0);
    chk({tag, "_overrun"}, Overrun, 0);
    chk({tag, "_busy"}, Busy, 0);
  endtask

  task automatic do_reset();
    Reset = 0;
    @(posedge Clock);
    #1;
    @(posedge Clock);
    #1;
    Reset = 1;
  endtask

  initial begin
    Accept = 0;
    idle_inputs();
    do_reset();
    chk_zero("reset");

    // Nominal run with Busy tracking.
    push_exp(2, 8'hBD, 5, 8'h99, 3, 8'h7E);
    drive(0, 1, 0, 0, 8'hBD);
    chk("busy_rise", Busy, 1);
    drive(0, 1, 0, 0, 8'hBD);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 8'h99);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 8'h7E);
    chk("valid_before_ready", Valid, 0);
    drive(1, 0, 0, 0, 8'h00);
    idle_inputs();
    chk("busy_fall", Busy, 0);
    check_result("nominal");
    chk("nominal_sum_const", Sum, 10'h1D4);
    accept_pulse("nominal");

    // Length mismatches.
    push_exp(2, 8'h11, 4, 8'h22, 3, 8'h33);
    run(2, 8'h11, 4, 8'h22, 3, 8'h33, 0);
    check_result("op2_short");
    accept_pulse("op2_short");
    push_exp(8, 8'h44, 5, 8'h55, 3, 8'h66);
    run(8, 8'h44, 5, 8'h55, 3, 8'h66, 0);
    check_result("op1_sat");
    accept_pulse("op1_sat");

    // Second result dropped while first unconsumed; back-to-back runs.
    push_exp(2, 8'h01, 5, 8'h02, 3, 8'h03);
    run(2, 8'h01, 5, 8'h02, 3, 8'h03, 0);
    run(2, 8'hA0, 5, 8'hB0, 3, 8'hC0, 0);
    check_result("overrun_keep");
    chk("overrun_set", Overrun, 1);
    accept_pulse("overrun");

    // Accept on the completion edge lets the second result through.
    do_reset();
    push_exp(2, 8'h10, 5, 8'h20, 3, 8'h30);
    run(2, 8'h10, 5, 8'h20, 3, 8'h30, 0);
    check_result("acc_first");
    push_exp(2, 8'h0F, 5, 8'hF0, 3, 8'h5A);
    run(2, 8'h0F, 5, 8'hF0, 3, 8'h5A, 1);
    check_result("acc_second");
    chk("acc_no_overrun", Overrun, 0);
    accept_pulse("acc");

    // Op3 directly after Op1.
    drive(0, 1, 0, 0, 8'h12);
    drive(0, 1, 0, 0, 8'h12);
    drive(0, 0, 0, 1, 8'h34);
    idle_inputs();
    chk("op3_early_seqerr", SeqErr, 1);
    chk("op3_early_busy", Busy, 0);
    chk("op3_early_valid", Valid, 0);
    push_exp(2, 8'hC3, 5, 8'h3C, 3, 8'h81);
    run(2, 8'hC3, 5, 8'h3C, 3, 8'h81, 0);
    check_result("after_op3_err");
    accept_pulse("after_op3_err");

    // Op1 and Op2 together; fresh run starts on the following edge.
    do_reset();
    drive(0, 1, 0, 0, 8'h77);
    drive(0, 1, 1, 0, 8'h77);
    idle_inputs();
    chk("multi_seqerr", SeqErr, 1);
    chk("multi_busy", Busy, 0);
    push_exp(2, 8'h08, 5, 8'h09, 3, 8'h0A);
    run(2, 8'h08, 5, 8'h09, 3, 8'h0A, 0);
    check_result("after_multi");
    accept_pulse("after_multi");

    // All-ones data exercises the full sum width.
    push_exp(2, 8'hFF, 5, 8'hFF, 3, 8'hFF);
    run(2, 8'hFF, 5, 8'hFF, 3, 8'hFF, 0);
    check_result("all_ones");
    chk("all_ones_sum_const", Sum, 10'h2FD);

    // Reset mid-CAP2 with Valid still high.
    drive(0, 1, 0, 0, 8'h5E);
    drive(0, 1, 0, 0, 8'h5E);
    drive(0, 0, 1, 0, 8'h6F);
    drive(0, 0, 1, 0, 8'h6F);
    chk("midrun_busy", Busy, 1);
    chk("midrun_valid", Valid, 1);
    idle_inputs();
    Reset = 0;
    #2;
    chk_zero("async_reset");
    @(posedge Clock);
    #1;
    chk_zero("held_reset");
    Reset = 1;
    push_exp(2, 8'h2A, 5, 8'h4B, 3, 8'h6C);
    run(2, 8'h2A, 5, 8'h4B, 3, 8'h6C, 0);
    check_result("post_reset");
    accept_pulse("post_reset");
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
